// File: rtl/hdmi_pkg.sv
// Shared HDMI/frame-buffer definitions: image geometry, default bus widths
// and the frame-buffer port ownership codes.
package hdmi_pkg;

    localparam int IMG_X      = 640;
    localparam int IMG_Y      = 480;
    localparam int FB_WORDS   = IMG_X * IMG_Y;
    localparam int DEF_ADDR_W = 19;
    localparam int DEF_DATA_W = 24;

    // Ownership codes double as the arbiter state encoding and the GRANT output
    typedef enum logic [1:0] {
        GNT_IDLE = 2'b00,
        GNT_RD   = 2'b01,
        GNT_WR   = 2'b10
    } GrantState;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Requester-side bundle of the frame-buffer arbiter: display read channel
// plus the valid/ready image write channel.
interface fb_port_arbiter_if #(
    parameter int ADDR_W = hdmi_pkg::DEF_ADDR_W,
    parameter int DATA_W = hdmi_pkg::DEF_DATA_W
);

    logic              RD_REQ;
    logic [ADDR_W-1:0] RD_ADDR;
    logic [DATA_W-1:0] RD_DATA;
    logic              RD_VALID;
    logic              WR_VALID;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [DATA_W-1:0] WR_DATA;
    logic              WR_READY;

    modport master (
        output RD_REQ, RD_ADDR, WR_VALID, WR_ADDR, WR_DATA,
        input  RD_DATA, RD_VALID, WR_READY
    );

    modport slave (
        input  RD_REQ, RD_ADDR, WR_VALID, WR_ADDR, WR_DATA,
        output RD_DATA, RD_VALID, WR_READY
    );

endinterface

// File: rtl/fb_rd_pipe.sv
// Read-return path: a valid-tag delay line that follows each issued read
// through the RAM latency, then registers the returned word.
module fb_rd_pipe #(
    parameter int RD_LAT = 1,
    parameter int DATA_W = 24
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              issue_i,
    input  logic [DATA_W-1:0] memRdata_i,
    output logic [DATA_W-1:0] rdData_o,
    output logic              rdValid_o
);

    logic [RD_LAT:0]   tag_q;
    logic [RD_LAT:0]   tag_d;
    logic [DATA_W-1:0] rdData_q;
    logic              rdValid_q;

    // tag_q[0] marks the cycle the address is on the RAM, tag_q[RD_LAT] the data cycle
    assign tag_d = {tag_q[RD_LAT-1:0], issue_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_q     <= '0;
            rdValid_q <= 1'b0;
            rdData_q  <= '0;
        end else begin
            tag_q     <= tag_d;
            rdValid_q <= tag_q[RD_LAT];
            if (tag_q[RD_LAT]) begin
                rdData_q <= memRdata_i;
            end
        end
    end

    assign rdData_o  = rdData_q;
    assign rdValid_o = rdValid_q;

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: display reads always win, the image
// writer gets the port in read-free cycles; adds starvation and frame write counters.
module fb_port_arbiter
    import hdmi_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 800,
    parameter int CNT_W        = 12
) (
    input  logic              CLK_PX,
    input  logic              RST_n,
    fb_port_arbiter_if.slave  bus,
    input  logic              FRAME_START,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic              MEM_WE,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic [1:0]        GRANT,
    output logic              WR_STARVED,
    output logic [ADDR_W:0]   WR_COUNT
);

    localparam logic [CNT_W-1:0] STARVE_MAX   = '1;
    localparam logic [CNT_W-1:0] STARVE_LIM_C = CNT_W'(STARVE_LIMIT);
    localparam logic [ADDR_W:0]  WRCNT_MAX    = '1;

    GrantState         state_q, state_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic              memWe_q;
    logic [CNT_W-1:0]  starveCnt_q, starveCnt_d;
    logic              starved_q, starved_d;
    logic [ADDR_W:0]   wrCount_q, wrCount_d;
    logic              wrHandshake;
    logic              wrBlocked;

    // Ready is a pure function of the read request so the writer can never deadlock on it
    assign bus.WR_READY = RST_n & ~bus.RD_REQ;
    assign wrHandshake  = bus.WR_VALID & bus.WR_READY;
    assign wrBlocked    = bus.WR_VALID & ~bus.WR_READY;

    always_ff @(posedge CLK_PX or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= GNT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = GNT_IDLE;
        if (bus.RD_REQ) begin
            state_d = GNT_RD;
        end else if (bus.WR_VALID) begin
            state_d = GNT_WR;
        end
    end

    always_comb begin
        GRANT = state_q;
    end

    // Idle cycles keep the last address/data on the RAM pins to avoid needless toggling
    always_comb begin
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        unique case (state_d)
            GNT_RD: memAddr_d = bus.RD_ADDR;
            GNT_WR: begin
                memAddr_d  = bus.WR_ADDR;
                memWdata_d = bus.WR_DATA;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_PX or negedge RST_n) begin
        if (!RST_n) begin
            memAddr_q  <= '0;
            memWdata_q <= '0;
            memWe_q    <= 1'b0;
        end else begin
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            memWe_q    <= (state_d == GNT_WR);
        end
    end

    always_comb begin
        starveCnt_d = '0;
        if (wrBlocked) begin
            starveCnt_d = (starveCnt_q == STARVE_MAX) ? starveCnt_q : starveCnt_q + 1'b1;
        end
        starved_d = (starveCnt_d >= STARVE_LIM_C);
    end

    // A frame start restarts the count, but a write landing in that same cycle still counts
    always_comb begin
        wrCount_d = wrCount_q;
        if (FRAME_START) begin
            wrCount_d = wrHandshake ? (ADDR_W+1)'(1) : '0;
        end else if (wrHandshake && (wrCount_q != WRCNT_MAX)) begin
            wrCount_d = wrCount_q + 1'b1;
        end
    end

    always_ff @(posedge CLK_PX or negedge RST_n) begin
        if (!RST_n) begin
            starveCnt_q <= '0;
            starved_q   <= 1'b0;
            wrCount_q   <= '0;
        end else begin
            starveCnt_q <= starveCnt_d;
            starved_q   <= starved_d;
            wrCount_q   <= wrCount_d;
        end
    end

    fb_rd_pipe #(
        .RD_LAT (RD_LAT),
        .DATA_W (DATA_W)
    ) u_rdPipe (
        .clk_i      (CLK_PX),
        .rst_ni     (RST_n),
        .issue_i    (state_d == GNT_RD),
        .memRdata_i (MEM_RDATA),
        .rdData_o   (bus.RD_DATA),
        .rdValid_o  (bus.RD_VALID)
    );

    assign MEM_ADDR   = memAddr_q;
    assign MEM_WDATA  = memWdata_q;
    assign MEM_WE     = memWe_q;
    assign WR_STARVED = starved_q;
    assign WR_COUNT   = wrCount_q;

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares one single-port frame-buffer RAM (IMG_X*IMG_Y words, 24 bit) between two requesters.
  - The display read path (HDMI pixel fetch) has absolute priority.
  - The image write path (loader/overlay writer) uses a valid/ready handshake and takes the port only in cycles with no read request.
- Sits between the HDMI controller's pixel-address output and the frame-buffer RAM.
- Adds write-starvation monitoring and a per-frame write counter.

Parameters:
- ADDR_W, 19, frame-buffer address width.
- DATA_W, 24, pixel word width.
- RD_LAT, 1, RAM read latency in cycles from MEM_ADDR registered to MEM_RDATA valid (legal 1..4).
- STARVE_LIMIT, 800, count of consecutive blocked write cycles at which WR_STARVED asserts.
- CNT_W, 12, width of the starvation counter (saturating).

Ports:
- CLK_PX  in  1  pixel clock, single clock domain.
- RST_n  in  1  asynchronous active-low reset.
- RD_REQ  in  1  display read request, one word per cycle.
- RD_ADDR  in  ADDR_W  read address, sampled with RD_REQ.
- RD_DATA  out  DATA_W  returned pixel.
- RD_VALID  out  1  RD_DATA valid strobe.
- WR_VALID  in  1  writer has a word.
- WR_ADDR  in  ADDR_W  write address.
- WR_DATA  in  DATA_W  write data.
- WR_READY  out  1  writer accepted this cycle when WR_VALID is also high.
- FRAME_START  in  1  one-cycle pulse at frame start (from the vertical counter wrap).
- MEM_ADDR  out  ADDR_W  RAM address (registered).
- MEM_WDATA  out  DATA_W  RAM write data (registered).
- MEM_WE  out  1  RAM write enable (registered).
- MEM_RDATA  in  DATA_W  RAM read data.
- GRANT  out  2  current owner: 00 idle, 01 read, 10 write.
- WR_STARVED  out  1  writer blocked for too long.
- WR_COUNT  out  ADDR_W+1  writes committed since last FRAME_START.

Behaviour:
- Reset (asynchronous, RST_n low), applied immediately:
  - MEM_ADDR, MEM_WDATA, MEM_WE, RD_DATA, RD_VALID, WR_STARVED and WR_COUNT go to 0.
  - GRANT goes to 00; the state goes to IDLE.
  - The read-tag pipeline clears. In-flight reads are dropped and never produce RD_VALID.
  - WR_READY is 0 while in reset.
- Arbitration, decided combinationally in cycle t:
  - WR_READY = RST_n-qualified !RD_REQ. WR_READY must not depend on WR_VALID.
  - RD_REQ=1: read wins.
  - RD_REQ=0 and WR_VALID=1: write wins.
  - Otherwise: idle.
- State machine (IDLE / RD / WR) registers the decision at the edge ending cycle t. GRANT encodes the state.
  - Any state may go to any state in one cycle; there are no turnaround bubbles.
- Memory port, cycle t+1:
  - Read grant: MEM_ADDR=RD_ADDR, MEM_WE=0.
  - Write grant: MEM_ADDR=WR_ADDR, MEM_WDATA=WR_DATA, MEM_WE=1.
  - Idle: MEM_WE=0; MEM_ADDR and MEM_WDATA hold their last values.
- Read return:
  - A 1-bit tag shift register of depth RD_LAT+1 tracks issued reads.
  - RD_DATA is registered from MEM_RDATA. RD_VALID=1 exactly in cycle t+1+RD_LAT+1 for a request in cycle t, i.e. fixed total latency RD_LAT+2 cycles.
  - Back-to-back reads stream one word per cycle, in order.
- Ordering: port accesses execute in grant order. A write at t followed by a read of the same address at t+1 returns the new data.
- Starvation counter:
  - Increments each cycle with WR_VALID=1 and WR_READY=0, saturating at 2^CNT_W-1.
  - Clears on a handshake or when WR_VALID=0.
  - WR_STARVED is registered: 1 while counter >= STARVE_LIMIT, otherwise 0.
- WR_COUNT:
  - Increments by 1 per write handshake and saturates at all-ones.
  - FRAME_START sets WR_COUNT to 0.
  - FRAME_START together with a handshake in the same cycle sets WR_COUNT to 1.
- Width rules: all counters are unsigned, with no wrap-around (saturating). Addresses are passed through unmodified; range checking is the requester's job.

Decomposition:
- Shared package hdmi_pkg holds:
  - The GRANT encodings (GNT_IDLE, GNT_RD, GNT_WR).
  - The IMG_X and IMG_Y constants.
  - The default ADDR_W and DATA_W.
- One natural sub-module: fb_rd_pipe, the parameterised RD_LAT+1-deep valid-tag delay line plus output data register.

Test Plan:
- Reads only: RD_REQ high for 4 cycles, addresses 0..3, RAM preloaded with value = address, RD_LAT=1 -> RD_VALID high cycles 3..6 after the first request; RD_DATA 0,1,2,3; MEM_WE stays 0.
- Write only: WR_VALID with addresses 10/11, data 0xAA55AA/0x123456, RD_REQ=0 -> WR_READY=1 both cycles; MEM_WE=1 for 2 cycles with matching address/data; WR_COUNT=2.
- Contention: RD_REQ and WR_VALID high for 3 cycles, then RD_REQ low -> WR_READY=0 for 3 cycles; the write issues in cycle 5; GRANT sequence 01,01,01,10.
- Starvation: STARVE_LIMIT=8, RD_REQ held high for 20 cycles with WR_VALID=1 -> WR_STARVED rises after 8 blocked cycles and clears the cycle after the first accepted write.
- RAW hazard: write 0xFF0000 to address 5, then read address 5 next cycle -> RD_DATA=0xFF0000.
- Reset mid-read with a read pending: pulse RST_n low -> outputs return to 0 immediately and no spurious RD_VALID appears. Separately, FRAME_START in the same cycle as a handshake -> WR_COUNT=1.
